// File: rtl/barrel_spawn_scheduler_pkg.sv
// Shared types and constants for the barrel spawn scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package barrel_spawn_scheduler_pkg;

  // Largest barrel population any build of the scheduler supports.
  localparam int BARREL_NUM_MAX = 32;

  // Width of the saturating discarded-request counter.
  localparam int MISS_W = 8;

  // Width of the launch cooldown counter (holds GAP_TICKS up to 255).
  localparam int COOL_W = 8;

  // Scheduler FSM encoding.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_COOL   = 2'd2
  } sched_state_e;

  // Game state codes shared with the top-level game state machine.
  typedef enum logic [1:0] {
    GAME_ATTRACT = 2'd0,
    GAME_RUNNING = 2'd1,
    GAME_DYING   = 2'd2,
    GAME_OVER    = 2'd3
  } game_state_e;

endpackage

// File: rtl/barrel_spawn_scheduler_if.sv
// Bundle between gameplay core / barrel array and the spawn scheduler.
// Latency: n/a (wires only).
// Backpressure: none; drop requests are edge events, excess ones are counted as misses.
interface barrel_spawn_scheduler_if
  import barrel_spawn_scheduler_pkg::*;
#(
  parameter int NUM_SLOTS = 16,
  parameter int IDX_W     = 4
);
  logic                 game_run;
  logic                 tick;
  logic                 drop_req;
  logic [NUM_SLOTS-1:0] slot_done;
  logic [NUM_SLOTS-1:0] start_vec;
  logic [NUM_SLOTS-1:0] busy_vec;
  logic [IDX_W-1:0]     spawn_idx;
  logic [IDX_W:0]       active_cnt;
  logic                 miss_pulse;
  logic [MISS_W-1:0]    miss_cnt;

  // Game side: drives requests/retires, observes launches.
  modport master (
    output game_run, tick, drop_req, slot_done,
    input  start_vec, busy_vec, spawn_idx, active_cnt, miss_pulse, miss_cnt
  );

  // Scheduler side.
  modport slave (
    input  game_run, tick, drop_req, slot_done,
    output start_vec, busy_vec, spawn_idx, active_cnt, miss_pulse, miss_cnt
  );
endinterface

// File: rtl/barrel_spawn_scheduler_rr_free_finder.sv
// Rotating priority encoder: first non-busy slot at or after rr_ptr, wrapping.
// Latency: combinational.
// Backpressure: none; found=0 when every slot is busy.
module barrel_spawn_scheduler_rr_free_finder #(
  parameter int NUM_SLOTS = 16,
  parameter int IDX_W     = 4
) (
  input  logic [NUM_SLOTS-1:0] busy_vec,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic                 found,
  output logic [IDX_W-1:0]     idx
);
  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down so the nearest free slot wins last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      cand = rr_ptr + IDX_W'(i);  // power-of-two slot count: natural wrap
      if (!busy_vec[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end
endmodule

// File: rtl/barrel_spawn_scheduler.sv
// Allocates barrel slots round-robin on Kong drop requests and fires one-clk start pulses.
// Latency: drop_req rise -> start_vec = 2 clk when IDLE with a free slot.
// Backpressure: one request may wait (pending); further requests are dropped and counted.
module barrel_spawn_scheduler
  import barrel_spawn_scheduler_pkg::*;
#(
  parameter int NUM_SLOTS = 16,
  parameter int IDX_W     = 4,
  parameter int GAP_TICKS = 8
) (
  input logic                    clk,
  input logic                    rst,
  barrel_spawn_scheduler_if.slave bus
);
  sched_state_e         state_q, state_d;
  logic                 drop_q;
  logic                 pending_q, pending_d;
  logic [COOL_W-1:0]    cooldown_q, cooldown_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     sel_q, sel_d;
  logic [IDX_W-1:0]     spawn_idx_q, spawn_idx_d;
  logic [NUM_SLOTS-1:0] busy_q, busy_d;
  logic [IDX_W:0]       active_cnt_q, active_cnt_d;
  logic                 miss_pulse_q, miss_pulse_d;
  logic [MISS_W-1:0]    miss_cnt_q, miss_cnt_d;
  logic [NUM_SLOTS-1:0] start_vec_c;
  logic                 req_edge;
  logic                 free_found;
  logic [IDX_W-1:0]     free_idx;

  // Requests only count while the game is running.
  assign req_edge = bus.game_run & bus.drop_req & ~drop_q;

  barrel_spawn_scheduler_rr_free_finder #(
    .NUM_SLOTS(NUM_SLOTS),
    .IDX_W    (IDX_W)
  ) u_finder (
    .busy_vec(busy_q),
    .rr_ptr  (rr_ptr_q),
    .found   (free_found),
    .idx     (free_idx)
  );

  // Start pulse decodes straight from state so an async reset kills it immediately.
  always_comb begin
    start_vec_c = '0;
    if (state_q == S_LAUNCH && bus.game_run) start_vec_c[sel_q] = 1'b1;
  end

  // Next-state: request capture, FSM, slot free/claim, flush, occupancy count.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    cooldown_d   = cooldown_q;
    rr_ptr_d     = rr_ptr_q;
    sel_d        = sel_q;
    spawn_idx_d  = spawn_idx_q;
    busy_d       = busy_q & ~bus.slot_done;  // retire on a free slot is a no-op
    miss_pulse_d = 1'b0;
    miss_cnt_d   = miss_cnt_q;
    active_cnt_d = '0;

    if (req_edge) begin
      if (pending_q) begin
        miss_pulse_d = 1'b1;
        if (miss_cnt_q != {MISS_W{1'b1}}) miss_cnt_d = miss_cnt_q + 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        // Slot is fixed here, one clk ahead of the pulse.
        if (pending_q && free_found) begin
          sel_d   = free_idx;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        busy_d[sel_q] = 1'b1;
        spawn_idx_d   = sel_q;
        rr_ptr_d      = sel_q + 1'b1;
        pending_d     = 1'b0;
        cooldown_d    = COOL_W'(GAP_TICKS);
        state_d       = S_COOL;
      end
      S_COOL: begin
        if (cooldown_q == '0) state_d = S_IDLE;
        else if (bus.tick)    cooldown_d = cooldown_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Leaving GAME_RUNNING wipes live barrels; pointer, last index and misses survive.
    if (!bus.game_run) begin
      busy_d      = '0;
      pending_d   = 1'b0;
      cooldown_d  = '0;
      state_d     = S_IDLE;
      rr_ptr_d    = rr_ptr_q;
      spawn_idx_d = spawn_idx_q;
    end

    for (int i = 0; i < NUM_SLOTS; i++) begin
      active_cnt_d = active_cnt_d + {{IDX_W{1'b0}}, busy_d[i]};
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      drop_q       <= 1'b0;
      pending_q    <= 1'b0;
      cooldown_q   <= '0;
      rr_ptr_q     <= '0;
      sel_q        <= '0;
      spawn_idx_q  <= '0;
      busy_q       <= '0;
      active_cnt_q <= '0;
      miss_pulse_q <= 1'b0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      drop_q       <= bus.drop_req;
      pending_q    <= pending_d;
      cooldown_q   <= cooldown_d;
      rr_ptr_q     <= rr_ptr_d;
      sel_q        <= sel_d;
      spawn_idx_q  <= spawn_idx_d;
      busy_q       <= busy_d;
      active_cnt_q <= active_cnt_d;
      miss_pulse_q <= miss_pulse_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign bus.start_vec  = start_vec_c;
  assign bus.busy_vec   = busy_q;
  assign bus.spawn_idx  = spawn_idx_q;
  assign bus.active_cnt = active_cnt_q;
  assign bus.miss_pulse = miss_pulse_q;
  assign bus.miss_cnt   = miss_cnt_q;
endmodule

// File: tb/tb_barrel_spawn_scheduler.sv
// Directed bench for barrel_spawn_scheduler: launch table plus corner-case sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_barrel_spawn_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  barrel_spawn_scheduler_if #(.NUM_SLOTS(16), .IDX_W(4)) bus ();

  barrel_spawn_scheduler #(
    .NUM_SLOTS(16),
    .IDX_W    (4),
    .GAP_TICKS(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] done_mask;  // retire pulse applied before the request
    logic [3:0]  exp_idx;    // slot expected to launch
    logic [15:0] exp_busy;   // occupancy after the launch
  } vec_t;

  vec_t vecs[17];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One request from IDLE: 2-clk latency, 1-clk pulse, then sit out the cooldown.
  task automatic launch_one(input logic [3:0] idx, input logic [15:0] exp_busy);
    logic [15:0] onehot;
    onehot = 16'h0001 << idx;
    bus.drop_req = 1'b1;
    step();
    check("start_early", 32'(bus.start_vec), 32'h0);
    bus.drop_req = 1'b0;
    step();
    check("start_vec", 32'(bus.start_vec), 32'(onehot));
    step();
    check("start_width", 32'(bus.start_vec), 32'h0);
    check("busy_vec", 32'(bus.busy_vec), 32'(exp_busy));
    check("spawn_idx", 32'(bus.spawn_idx), 32'(idx));
    check("active_cnt", 32'(bus.active_cnt), 32'($countones(exp_busy)));
    repeat (9) step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int waited;

    vecs[0] = '{16'h0000, 4'd0, 16'h0001};
    vecs[1] = '{16'h0000, 4'd1, 16'h0003};
    vecs[2] = '{16'h0000, 4'd2, 16'h0007};
    vecs[3] = '{16'h0001, 4'd3, 16'h000E};  // slot 0 free but rr_ptr=3 wins
    for (int i = 4; i < 16; i++) begin
      vecs[i] = '{16'h0000, 4'(i), 16'((32'h1 << (i + 1)) - 32'h2)};
    end
    vecs[16] = '{16'h0000, 4'd0, 16'hFFFF};  // pointer wraps 15 -> 0

    bus.game_run  = 1'b0;
    bus.tick      = 1'b0;
    bus.drop_req  = 1'b0;
    bus.slot_done = '0;
    repeat (2) step();

    // Reset state
    check("rst_start", 32'(bus.start_vec), 32'h0);
    check("rst_busy", 32'(bus.busy_vec), 32'h0);
    check("rst_spawn_idx", 32'(bus.spawn_idx), 32'h0);
    check("rst_active", 32'(bus.active_cnt), 32'h0);
    check("rst_miss_pulse", 32'(bus.miss_pulse), 32'h0);
    check("rst_miss_cnt", 32'(bus.miss_cnt), 32'h0);

    rst          = 1'b0;
    bus.game_run = 1'b1;
    bus.tick     = 1'b1;
    step();

    // Launch table: round robin, rr skip past a freed low slot, wrap to fill
    for (int v = 0; v < 17; v++) begin
      if (vecs[v].done_mask != 16'h0) begin
        bus.slot_done = vecs[v].done_mask;
        step();
        bus.slot_done = '0;
      end
      launch_one(vecs[v].exp_idx, vecs[v].exp_busy);
    end

    // All busy: request waits
    bus.drop_req = 1'b1;
    step();
    bus.drop_req = 1'b0;
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      step();
      if (bus.start_vec != 16'h0) seen++;
    end
    check("full_no_start", 32'(seen), 32'h0);
    check("full_no_miss", 32'(bus.miss_cnt), 32'h0);

    // Free slot 5 -> pending launches there 2 clk later
    bus.slot_done = 16'h0020;
    step();
    bus.slot_done = '0;
    check("free5_active", 32'(bus.active_cnt), 32'd15);
    check("free5_busy", 32'(bus.busy_vec), 32'hFFDF);
    check("free5_early", 32'(bus.start_vec), 32'h0);
    step();
    check("free5_start", 32'(bus.start_vec), 32'h0020);

    // Two requests during cooldown: one pending, one missed
    step();
    bus.slot_done = 16'h0200;
    bus.drop_req  = 1'b1;
    step();
    bus.slot_done = '0;
    bus.drop_req  = 1'b0;
    step();
    bus.drop_req = 1'b1;
    step();
    check("cool_miss_pulse", 32'(bus.miss_pulse), 32'h1);
    check("cool_miss_cnt", 32'(bus.miss_cnt), 32'h1);
    bus.drop_req = 1'b0;
    step();
    check("miss_pulse_width", 32'(bus.miss_pulse), 32'h0);
    waited = 0;
    for (int n = 1; n <= 30; n++) begin
      step();
      if (bus.start_vec != 16'h0) begin
        waited = n;
        break;
      end
    end
    check("cool_launch_delay", 32'(waited), 32'd6);
    check("cool_launch_slot", 32'(bus.start_vec), 32'h0200);

    // Flush while cooling with a request pending
    step();
    check("busy_full_again", 32'(bus.busy_vec), 32'hFFFF);
    bus.drop_req = 1'b1;
    step();
    bus.drop_req = 1'b0;
    bus.game_run = 1'b0;
    step();
    check("flush_busy", 32'(bus.busy_vec), 32'h0);
    check("flush_active", 32'(bus.active_cnt), 32'h0);
    check("flush_start", 32'(bus.start_vec), 32'h0);
    check("flush_miss_cnt", 32'(bus.miss_cnt), 32'h1);
    check("flush_spawn_idx", 32'(bus.spawn_idx), 32'd9);
    bus.game_run = 1'b1;
    seen = 0;
    for (int n = 0; n < 4; n++) begin
      step();
      if (bus.start_vec != 16'h0) seen++;
    end
    check("flush_pending_gone", 32'(seen), 32'h0);
    launch_one(4'd10, 16'h0400);  // IDLE straight away, rr_ptr kept

    // Async reset in the middle of a launch
    bus.drop_req = 1'b1;
    step();
    bus.drop_req = 1'b0;
    step();
    check("pre_rst_start", 32'(bus.start_vec), 32'h0800);
    rst = 1'b1;
    #1;
    check("arst_start", 32'(bus.start_vec), 32'h0);
    check("arst_busy", 32'(bus.busy_vec), 32'h0);
    check("arst_spawn_idx", 32'(bus.spawn_idx), 32'h0);
    check("arst_active", 32'(bus.active_cnt), 32'h0);
    check("arst_miss_cnt", 32'(bus.miss_cnt), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();

    // Refill, then flood with requests until the miss counter saturates
    for (int i = 0; i < 16; i++) begin
      launch_one(4'(i), 16'((32'h1 << (i + 1)) - 32'h1));
    end
    for (int k = 0; k < 300; k++) begin
      bus.drop_req = 1'b1;
      step();
      if (k == 1) check("flood_miss_pulse", 32'(bus.miss_pulse), 32'h1);
      bus.drop_req = 1'b0;
      step();
      if (k == 9) check("flood_miss_cnt_9", 32'(bus.miss_cnt), 32'd9);
    end
    check("miss_cnt_sat", 32'(bus.miss_cnt), 32'd255);
    check("flood_busy", 32'(bus.busy_vec), 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
